// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: control, input-stream, processor and result signals of mac_sequencer.
interface mac_sequencer_if #(
   parameter int DW = 8,
   parameter int N_MAX = 8,
   parameter int CNT_W = $clog2(N_MAX + 1),
   parameter int OW = 2 * DW + CNT_W
);
   logic start;
   logic [CNT_W-1:0] dim;
   logic busy;
   logic err;
   logic in_valid;
   logic in_ready;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic [DW-1:0] proc_a;
   logic [DW-1:0] proc_b;
   logic proc_enable;
   logic proc_retro;
   logic [OW-1:0] proc_out;
   logic proc_done;
   logic res_valid;
   logic res_ready;
   logic [OW-1:0] res_data;
   logic [CNT_W-1:0] res_row;
   modport slave (
      input start, dim, in_valid, in_a, in_b, proc_out, proc_done, res_ready,
      output busy, err, in_ready, proc_a, proc_b, proc_enable, proc_retro, res_valid, res_data, res_row
   );
   modport master (
      output start, dim, in_valid, in_a, in_b, proc_out, proc_done, res_ready,
      input busy, err, in_ready, proc_a, proc_b, proc_enable, proc_retro, res_valid, res_data, res_row
   );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: feeds row-major matrix/vector pairs into a MAC processor and returns each row dot-product.
// Define MAC_SEQ_TIMEOUT_EN to abort the product when proc_done does not arrive within TMO capture cycles.
module mac_sequencer #(
   parameter int DW = 8,
   parameter int N_MAX = 8,
   parameter int CNT_W = $clog2(N_MAX + 1),
   parameter int OW = 2 * DW + CNT_W,
   parameter int TMO = 15
) (
   input logic clk,
   input logic rst,
   mac_sequencer_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, CAPTURE = 2'd2, EMIT = 2'd3;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   logic [1:0] state;
   logic [CNT_W-1:0] n, row, col;
   logic accept, done_ok, dim_ok, last_col, last_row, tmo_hit;
   assign bus.in_ready = state == RUN;
   assign bus.res_valid = state == EMIT;
   assign bus.busy = state != IDLE;
   assign accept = bus.in_valid && state == RUN;
   // first CAPTURE cycle may still carry done of the second-last column; the last column's done comes with enable low
   assign done_ok = state == CAPTURE && bus.proc_done && !bus.proc_enable;
   assign dim_ok = bus.dim != '0 && bus.dim <= CNT_W'(N_MAX);
   assign last_col = col == n - ONE;
   assign last_row = row == n - ONE;
`ifdef MAC_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TMO + 1);
   logic [TW-1:0] tmo_cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) tmo_cnt <= '0;
      else tmo_cnt <= state == CAPTURE && !done_ok ? tmo_cnt + TW'(1) : '0;
   assign tmo_hit = state == CAPTURE && !done_ok && tmo_cnt == TW'(TMO - 1);
`else
   assign tmo_hit = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         n <= '0;
         row <= '0;
         col <= '0;
         bus.err <= 1'b0;
         bus.proc_a <= '0;
         bus.proc_b <= '0;
         bus.proc_enable <= 1'b0;
         bus.proc_retro <= 1'b0;
         bus.res_data <= '0;
         bus.res_row <= '0;
      end else begin
         bus.err <= (state == IDLE && bus.start && !dim_ok) || tmo_hit;
         bus.proc_enable <= accept;
         if (accept) begin
            bus.proc_a <= DW'(bus.in_a);
            bus.proc_b <= DW'(bus.in_b);
            bus.proc_retro <= col != '0;
            col <= col + ONE;
         end
         if (done_ok) begin
            bus.res_data <= OW'(bus.proc_out);
            bus.res_row <= row;
         end
         case (state)
            IDLE: if (bus.start && dim_ok) begin
               n <= bus.dim;
               row <= '0;
               col <= '0;
               state <= RUN;
            end
            RUN: if (accept && last_col) state <= CAPTURE;
            CAPTURE: state <= done_ok ? EMIT : tmo_hit ? IDLE : CAPTURE;
            default: if (bus.res_ready) begin
               col <= '0;
               row <= row + ONE;
               state <= last_row ? IDLE : RUN;
            end
         endcase
      end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: drives mac_sequencer with fixed and random matrix-vector products against a processor stub
// and checks every row result with a plain dot-product model; define MAC_SEQ_TIMEOUT_EN to also run the timeout test.
module tb_mac_sequencer;
   localparam int DW = 8, N_MAX = 8, CNT_W = $clog2(N_MAX + 1), OW = 2 * DW + CNT_W;
   logic clk = 1'b0, rst = 1'b0, kill = 1'b0, done_r = 1'b0, prev_acc = 1'b0;
   logic [OW-1:0] acc = '0;
   int checks = 0, errors = 0, en_bad = 0, err_cnt = 0, rv_cnt = 0;
   logic [DW-1:0] ma [64];
   logic [DW-1:0] vb [8];
   logic [OW-1:0] data_q [$];
   logic [CNT_W-1:0] row_q [$];
   logic retro_q [$];
   mac_sequencer_if #(.DW(DW), .N_MAX(N_MAX)) bus();
   mac_sequencer #(.DW(DW), .N_MAX(N_MAX), .TMO(15)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // processor stub: done one cycle after enable, retro accumulates onto the previous result
   always @(posedge clk) begin
      done_r <= bus.proc_enable;
      if (bus.proc_enable) acc <= (bus.proc_retro ? acc : '0) + OW'(bus.proc_a) * OW'(bus.proc_b);
   end
   assign bus.proc_out = acc;
   assign bus.proc_done = done_r && !kill;
   always @(negedge clk) begin
      if (bus.proc_enable !== prev_acc) en_bad++;
      prev_acc = bus.in_valid && bus.in_ready;
      if (bus.proc_enable) retro_q.push_back(bus.proc_retro);
      if (bus.res_valid && bus.res_ready) begin
         data_q.push_back(bus.res_data);
         row_q.push_back(bus.res_row);
      end
      if (bus.err) err_cnt++;
      if (bus.res_valid) rv_cnt++;
   end
   function automatic logic [2*DW+OW+CNT_W+5:0] outs();
      return {bus.busy, bus.err, bus.in_ready, bus.proc_enable, bus.proc_retro, bus.res_valid,
              bus.proc_a, bus.proc_b, bus.res_data, bus.res_row};
   endfunction
   function automatic int dot(input int n, input int r);
      int s = 0;
      for (int c = 0; c < n; c++) s += int'(ma[r*n+c]) * int'(vb[c]);
      return s;
   endfunction
   task automatic clear_obs();
      data_q.delete();
      row_q.delete();
      retro_q.delete();
      en_bad = 0;
      err_cnt = 0;
      rv_cnt = 0;
   endtask
   task automatic do_start(input int d);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.dim = CNT_W'(d);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask
   // gap < 0 inserts 0..2 random idle cycles before each pair
   task automatic feed(input int n, input int gap);
      for (int k = 0; k < n * n; k++) begin
         int w = 0;
         int g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
         repeat (g) begin @(posedge clk); #1; end
         bus.in_valid = 1'b1;
         bus.in_a = ma[k];
         bus.in_b = vb[k % n];
         do begin @(negedge clk); w++; end while (!bus.in_ready && w < 200);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         if (w >= 200) begin
            checks++; errors++;
            $display("FAIL feed_timeout: pair %0d not accepted, in_ready=%b want 1", k, bus.in_ready);
            return;
         end
      end
   endtask
   task automatic consume(input int n, input int maxhold);
      for (int r = 0; r < n; r++) begin
         int w = 0;
         while (!bus.res_valid && w < 200) begin @(negedge clk); w++; end
         if (!bus.res_valid) begin
            checks++; errors++;
            $display("FAIL consume_timeout: row %0d res_valid=%b want 1", r, bus.res_valid);
            return;
         end
         repeat ($urandom_range(0, maxhold)) @(negedge clk);
         @(posedge clk); #1;
         bus.res_ready = 1'b1;
         @(posedge clk); #1;
         bus.res_ready = 1'b0;
      end
   endtask
   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (outs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs()); end
      rst = 1'b1;
   endtask
   task automatic test_back_to_back();
      ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4; vb[0] = 5; vb[1] = 6;
      clear_obs();
      do_start(2);
      fork feed(2, 0); consume(2, 0); join
      @(negedge clk);
      checks++;
      if (data_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", data_q.size()); end
      checks++;
      if (data_q[0] !== OW'(17) || row_q[0] !== 0) begin errors++; $display("FAIL b2b_row0: got %0d/%0d want 17/0", data_q[0], row_q[0]); end
      checks++;
      if (data_q[1] !== OW'(39) || row_q[1] !== 1) begin errors++; $display("FAIL b2b_row1: got %0d/%0d want 39/1", data_q[1], row_q[1]); end
      checks++;
      if (retro_q.size() != 4 || {retro_q[0], retro_q[1], retro_q[2], retro_q[3]} !== 4'b0101 || en_bad != 0) begin
         errors++; $display("FAIL b2b_retro: n=%0d en_bad=%0d want 4 enables 0,1,0,1", retro_q.size(), en_bad);
      end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", bus.busy); end
   endtask
   task automatic test_single();
      ma[0] = 7; vb[0] = 3;
      clear_obs();
      do_start(1);
      fork feed(1, 0); consume(1, 0); join
      checks++;
      if (data_q.size() != 1 || data_q[0] !== OW'(21) || row_q[0] !== 0) begin
         errors++; $display("FAIL single_result: got %0d/%0d (n=%0d) want 21/0", data_q[0], row_q[0], data_q.size());
      end
      checks++;
      if (retro_q.size() != 1 || retro_q[0] !== 1'b0) begin errors++; $display("FAIL single_retro: got %0d enables retro=%b want 1/0", retro_q.size(), retro_q[0]); end
   endtask
   task automatic test_backpressure();
      ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4; vb[0] = 5; vb[1] = 6;
      clear_obs();
      do_start(2);
      fork
         feed(2, 0);
         begin
            int w = 0;
            while (!bus.res_valid && w < 200) begin @(negedge clk); w++; end
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               checks++;
               if (bus.res_valid !== 1'b1 || bus.res_data !== OW'(17) || bus.in_ready !== 1'b0 || bus.proc_enable !== 1'b0) begin
                  errors++;
                  $display("FAIL bp_hold cycle %0d: valid=%b data=%0d in_ready=%b en=%b want 1/17/0/0",
                           i, bus.res_valid, bus.res_data, bus.in_ready, bus.proc_enable);
               end
            end
            @(posedge clk); #1;
            bus.res_ready = 1'b1;
            @(posedge clk); #1;
            bus.res_ready = 1'b0;
            consume(1, 0);
         end
      join
      checks++;
      if (data_q.size() != 2 || data_q[0] !== OW'(17) || data_q[1] !== OW'(39)) begin
         errors++; $display("FAIL bp_results: got %0d,%0d (n=%0d) want 17,39", data_q[0], data_q[1], data_q.size());
      end
   endtask
   task automatic test_gaps();
      for (int k = 0; k < 9; k++) ma[k] = 1;
      for (int c = 0; c < 3; c++) vb[c] = 1;
      clear_obs();
      do_start(3);
      fork feed(3, 1); consume(3, 1); join
      for (int r = 0; r < 3; r++) begin
         checks++;
         if (data_q[r] !== OW'(3) || row_q[r] !== CNT_W'(r)) begin errors++; $display("FAIL gaps_row%0d: got %0d/%0d want 3/%0d", r, data_q[r], row_q[r], r); end
      end
      checks++;
      if (retro_q.size() != 9 || en_bad != 0) begin errors++; $display("FAIL gaps_enable: got %0d enables, %0d misaligned want 9/0", retro_q.size(), en_bad); end
   endtask
   task automatic test_illegal_dim();
      clear_obs();
      for (int i = 0; i < 2; i++) begin
         do_start(i == 0 ? 0 : N_MAX + 1);
         checks++;
         if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL illegal_err dim%0d: err=%b busy=%b want 1/0", i, bus.err, bus.busy); end
         @(posedge clk); #1;
         checks++;
         if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL illegal_after dim%0d: err=%b busy=%b in_ready=%b want 0/0/0", i, bus.err, bus.busy, bus.in_ready);
         end
      end
      checks++;
      if (err_cnt != 2) begin errors++; $display("FAIL illegal_pulses: got %0d want 2", err_cnt); end
   endtask
   task automatic test_reset_mid_row();
      clear_obs();
      do_start(2);
      bus.in_valid = 1'b1;
      bus.in_a = 1;
      bus.in_b = 5;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (outs() !== '0) begin errors++; $display("FAIL midrow_reset: got %h want 0", outs()); end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      test_back_to_back();
   endtask
   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         int n = it == 0 ? N_MAX : int'($urandom_range(1, N_MAX));
         int bad = 0;
         for (int k = 0; k < n * n; k++) ma[k] = it == 0 ? 8'hFF : 8'($urandom);
         for (int c = 0; c < n; c++) vb[c] = it == 0 ? 8'hFF : 8'($urandom);
         clear_obs();
         do_start(n);
         fork feed(n, -1); consume(n, 3); join
         for (int r = 0; r < n; r++) begin
            checks++;
            if (data_q[r] !== OW'(dot(n, r)) || row_q[r] !== CNT_W'(r)) begin
               errors++; $display("FAIL rand it%0d row%0d: got %0d/%0d want %0d/%0d", it, r, data_q[r], row_q[r], dot(n, r), r);
            end
         end
         for (int k = 0; k < retro_q.size(); k++) if (retro_q[k] !== (k % n != 0)) bad++;
         checks++;
         if (retro_q.size() != n * n || bad != 0 || en_bad != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_ctrl it%0d: enables=%0d bad_retro=%0d misaligned=%0d busy=%b want %0d/0/0/0",
                     it, retro_q.size(), bad, en_bad, bus.busy, n * n);
         end
      end
   endtask
`ifdef MAC_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int cyc = 0;
      ma[0] = 7; vb[0] = 3;
      clear_obs();
      kill = 1'b1;
      do_start(1);
      feed(1, 0);
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.err) break;
      end
      checks++;
      if (cyc != 16) begin errors++; $display("FAIL timeout_latency: err after %0d cycles want 16", cyc); end
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.err !== 1'b0 || rv_cnt != 0) begin
         errors++; $display("FAIL timeout_state: busy=%b err=%b res_valid cycles=%0d want 0/0/0", bus.busy, bus.err, rv_cnt);
      end
      kill = 1'b0;
   endtask
`endif
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      bus.start = 1'b0;
      bus.dim = '0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.res_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_single();
      test_backpressure();
      test_gaps();
      test_illegal_dim();
      test_reset_mid_row();
      test_random();
`ifdef MAC_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
